meter_cmd_sched: RTL and testbench
==================================

// Module: meter_cmd_sched
// PURPOSE
//  Front-end command scheduler for the parking-meter time datapath. Synchronises the six raw
//  push-buttons (add1..add4, rst1, rst2), edge-detects them, queues one pending request per
//  button, and issues a single prioritised command at a time over a valid/ready handshake.
//  A held add button auto-repeats, so a long press drives the count toward its 9999 clamp.
// PARAMETERS
//  REPEAT_DLY  50  clk cycles a held add button must stay high before first auto-repeat (0.5 s @100 Hz)
//  REPEAT_PER  10  clk cycles between auto-repeats while still held (0.1 s @100 Hz); >=1
// PORTS
//  clk        in   1  system clock (100 Hz in the meter build)
//  rst        in   1  asynchronous, active-low reset
//  add1       in   1  raw button, request +60 s
//  add2       in   1  raw button, request +120 s
//  add3       in   1  raw button, request +180 s
//  add4       in   1  raw button, request +300 s
//  rst1       in   1  raw button, request preset to 15 s
//  rst2       in   1  raw button, request preset to 185 s
//  cmd_valid  out  1  command presented to the time datapath
//  cmd_op     out  3  0 NOP, 1 ADD60, 2 ADD120, 3 ADD180, 4 ADD300, 5 SET15, 6 SET185
//  cmd_ready  in   1  datapath accepts cmd_op this cycle when cmd_valid=1
//  overrun    out  1  one-cycle pulse: a new edge hit an already-pending request (coalesced)
// BEHAVIOUR
//  - Reset (rst=0, async): all sync flops, pending bits, hold counters, FSM -> 0; cmd_valid=0,
//    cmd_op=0, overrun=0. On release, buttons already high do NOT produce an edge.
//  - Sync: 2-flop synchroniser per button; edge = sync2 & ~sync2_d. Edge sets pend[i] on the
//    following clk. Latency: raw high sampled at edge k -> pend at k+3 -> cmd_valid at k+4 (idle FSM).
//  - Priority (high->low): rst2, rst1, add4, add3, add2, add1.
//  - FSM IDLE: if any pend, latch highest-priority op into cmd_op, clear that pend bit,
//    cmd_valid=1, go ISSUE. Else cmd_valid=0, cmd_op=0.
//  - FSM ISSUE: cmd_valid, cmd_op held stable until cmd_valid&cmd_ready; on that edge go IDLE
//    (cmd_valid drops for one cycle minimum between commands). cmd_ready ignored in IDLE.
//  - Preset wins: issuing SET15/SET185 clears every add pend bit set before that cycle;
//    adds pressed afterwards queue normally. rst1 and rst2 both pending -> SET185 only, rst1 dropped.
//  - Coalescing: edge on button i while pend[i]=1 (or same op in ISSUE) -> not queued, overrun=1
//    for one cycle. Simultaneous edges on different buttons all queue.
//  - Auto-repeat: one hold tracker for the highest-priority add button currently held (sync2=1).
//    Counter starts at its edge; at REPEAT_DLY cycles held, set its pend; then every REPEAT_PER
//    cycles. Repeat into an already-set pend is silent (no overrun). Release or a higher-priority
//    add going high restarts tracking. rst1/rst2 never repeat.
//  - Counters saturate; no wrap. Width = clog2(REPEAT_DLY+1).
//  - Clamp to 9999 and value arithmetic belong to the datapath, not this block.
// TESTING (REPEAT_DLY=50, REPEAT_PER=10, cmd_ready=1 unless stated)
//  1 rst=0 mid-ISSUE with add2 pending -> cmd_valid=0, cmd_op=0 same cycle; no cmd after release.
//  2 add1 high 1 cycle -> exactly one cmd_valid pulse, cmd_op=1, 4 edges after sampling.
//  3 add1 and rst2 rise same cycle -> single cmd SET185 (op 6); ADD60 never issued.
//  4 cmd_ready=0, pulse add3 twice -> ADD180 held stable, second edge gives overrun=1, only one ADD180.
//  5 add4 held 300 cycles -> 1 edge cmd + repeats at 50,60,...,290 => 26 ADD300 commands.
//  6 add2 then add3 edges 1 cycle apart, cmd_ready=0 for 5 cycles -> ADD120 first, then ADD180.

Source files
------------

// File: rtl/meter_cmd_sched.sv
// Parking-meter command scheduler: synchronises and edge-detects six buttons,
// queues one pending request per button, auto-repeats a held add button and
// issues one prioritised command at a time over a valid/ready handshake.
module meter_cmd_sched #(
    parameter int unsigned REPEAT_DLY = 50,
    parameter int unsigned REPEAT_PER = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       add1_i,
    input  logic       add2_i,
    input  logic       add3_i,
    input  logic       add4_i,
    input  logic       rst1_i,
    input  logic       rst2_i,
    output logic       cmd_valid_o,
    output logic [2:0] cmd_op_o,
    input  logic       cmd_ready_i,
    output logic       overrun_o
);

    localparam int unsigned CntW = ($clog2(REPEAT_DLY + 1) > 0) ? $clog2(REPEAT_DLY + 1) : 1;
    localparam logic [CntW-1:0] DlyVal = CntW'(REPEAT_DLY);
    // Reloading here makes the counter hit DlyVal again after REPEAT_PER cycles.
    localparam logic [CntW-1:0] ReloadVal =
        (REPEAT_PER > REPEAT_DLY) ? '0 : CntW'(REPEAT_DLY - REPEAT_PER + 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    // Bit order doubles as priority: bit 5 (rst2) highest, bit 0 (add1) lowest.
    logic [5:0] raw_w;
    assign raw_w = {rst2_i, rst1_i, add4_i, add3_i, add2_i, add1_i};

    logic [5:0]      sync1_q, sync2_q, sync2d_q, edge_q, pend_q, pend_d;
    logic [1:0]      arm_q;
    logic [5:0]      edge_w, busy_w;
    logic            armed_w;
    logic            trk_act_q, trk_act_d;
    logic [1:0]      trk_q, trk_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      hi_w;
    logic            any_held_w, start_w, fire_w;
    logic [3:0]      rep_w;
    logic [2:0]      sel_w;
    logic            issue_w, preset_w, ovr_w;
    state_e          state_q;
    logic            cmd_valid_q, overrun_q;
    logic [2:0]      cmd_op_q;

    // Edges are masked until the synchroniser has filled after reset, so a
    // button already held at reset release is not seen as a press.
    assign armed_w = (arm_q == 2'd3);
    assign edge_w  = sync2_q & ~sync2d_q & {6{armed_w}};

    // Synchroniser, edge register and post-reset arming counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync2d_q <= '0;
            edge_q   <= '0;
            arm_q    <= '0;
        end else begin
            sync1_q  <= raw_w;
            sync2_q  <= sync1_q;
            sync2d_q <= sync2_q;
            edge_q   <= edge_w;
            if (!armed_w) arm_q <= arm_q + 2'd1;
        end
    end

    // Highest-priority held add button and its auto-repeat tracking.
    always_comb begin
        hi_w       = '0;
        any_held_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i]) begin
                hi_w       = 2'(i);
                any_held_w = 1'b1;
            end
        end
        start_w   = any_held_w && edge_w[hi_w];
        fire_w    = 1'b0;
        trk_act_d = 1'b0;
        trk_d     = trk_q;
        cnt_d     = '0;
        if (start_w) begin
            trk_act_d = 1'b1;
            trk_d     = hi_w;
            cnt_d     = CntW'(1);
        end else if (trk_act_q && any_held_w && (hi_w == trk_q)) begin
            trk_act_d = 1'b1;
            fire_w    = (cnt_q == DlyVal);
            cnt_d     = (cnt_q == DlyVal) ? ReloadVal : cnt_q + CntW'(1);
        end
        rep_w = '0;
        if (fire_w) rep_w[trk_q] = 1'b1;
    end

    // Hold tracker state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_act_q <= 1'b0;
            trk_q     <= '0;
            cnt_q     <= '0;
        end else begin
            trk_act_q <= trk_act_d;
            trk_q     <= trk_d;
            cnt_q     <= cnt_d;
        end
    end

    // Issue selection, coalescing detection and pending-bit next state.
    always_comb begin
        sel_w = '0;
        for (int i = 0; i < 6; i++) begin
            if (pend_q[i]) sel_w = 3'(i);
        end
        issue_w  = (state_q == StIdle) && (|pend_q);
        preset_w = issue_w && (sel_w >= 3'd4);
        for (int i = 0; i < 6; i++) begin
            busy_w[i] = pend_q[i] || ((state_q == StIssue) && (cmd_op_q == 3'(i + 1)));
        end
        ovr_w  = |(edge_q & busy_w);
        pend_d = pend_q;
        if (issue_w) pend_d[sel_w] = 1'b0;
        // A preset discards queued adds, and SET185 swallows a pending SET15.
        if (preset_w) pend_d[4:0] = '0;
        pend_d      = pend_d | (edge_q & ~busy_w);
        pend_d[3:0] = pend_d[3:0] | (rep_w & ~pend_q[3:0]);
    end

    // Pending request bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Command FSM with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= ovr_w;
            unique case (state_q)
                StIdle: begin
                    if (issue_w) begin
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= sel_w + 3'd1;
                        state_q     <= StIssue;
                    end else begin
                        cmd_valid_q <= 1'b0;
                        cmd_op_q    <= '0;
                    end
                end
                StIssue: begin
                    if (cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        cmd_op_q    <= '0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_op_o    = cmd_op_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_meter_cmd_sched.sv
// Self-checking bench for meter_cmd_sched: a scoreboard queue holds expected
// ops in issue order and is popped on every accepted command.
module tb_meter_cmd_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] btn;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int n_cmd    = 0;
    int n_ovr    = 0;
    logic [2:0] sb[$];

    meter_cmd_sched #(.REPEAT_DLY(50), .REPEAT_PER(10)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .add1_i      (btn[0]),
        .add2_i      (btn[1]),
        .add3_i      (btn[2]),
        .add4_i      (btn[3]),
        .rst1_i      (btn[4]),
        .rst2_i      (btn[5]),
        .cmd_valid_o (cmd_valid),
        .cmd_op_o    (cmd_op),
        .cmd_ready_i (cmd_ready),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    // Accepted commands are compared against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) n_ovr++;
            if (cmd_valid && cmd_ready) begin
                n_cmd++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got op=%0d, expected no command", cmd_op);
                end else begin
                    logic [2:0] exp_op;
                    exp_op = sb.pop_front();
                    if (cmd_op !== exp_op) begin
                        failures++;
                        $display("FAIL sb_op: got op=%0d, expected op=%0d", cmd_op, exp_op);
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [5:0] m);
        btn = btn | m;
        tick(1);
        btn = btn & ~m;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!cmd_valid && n < 20) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_ready = 1'b1;
        btn       = 6'b000100;  // add3 held through reset release
        tick(3);
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++; $display("FAIL rst_valid: got %b, expected 0", cmd_valid);
        end
        checks++;
        if (cmd_op !== 3'd0) begin
            failures++; $display("FAIL rst_op: got %0d, expected 0", cmd_op);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL rst_overrun: got %b, expected 0", overrun);
        end
        rst_n = 1'b1;
        tick(30);
        btn = '0;
        tick(5);
        checks++;
        if (n_cmd !== 0) begin
            failures++; $display("FAIL rst_held_no_edge: got %0d cmds, expected 0", n_cmd);
        end
    endtask

    task automatic test_reset_mid_issue();
        int base, n;
        base      = n_cmd;
        cmd_ready = 1'b0;
        pulse(6'b000001);
        sb.push_back(3'd1);
        wait_valid(n);
        checks++;
        if (n >= 20 || cmd_op !== 3'd1) begin
            failures++; $display("FAIL mid_issue_setup: got valid=%b op=%0d, expected 1/1", cmd_valid, cmd_op);
        end
        pulse(6'b000010);
        sb.push_back(3'd2);
        tick(6);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_op !== 3'd0) begin
            failures++; $display("FAIL mid_issue_async: got valid=%b op=%0d, expected 0/0", cmd_valid, cmd_op);
        end
        sb.delete();
        tick(2);
        rst_n     = 1'b1;
        cmd_ready = 1'b1;
        tick(30);
        checks++;
        if (n_cmd - base !== 0) begin
            failures++; $display("FAIL mid_issue_after: got %0d cmds, expected 0", n_cmd - base);
        end
    endtask

    task automatic test_latency();
        int base, n;
        base   = n_cmd;
        btn[0] = 1'b1;
        sb.push_back(3'd1);
        @(posedge clk);
        #1 btn[0] = 1'b0;
        n = 0;
        while (!cmd_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n !== 4) begin
            failures++; $display("FAIL latency: got %0d edges, expected 4", n);
        end
        checks++;
        if (cmd_op !== 3'd1) begin
            failures++; $display("FAIL latency_op: got %0d, expected 1", cmd_op);
        end
        tick(10);
        checks++;
        if (n_cmd - base !== 1) begin
            failures++; $display("FAIL latency_count: got %0d cmds, expected 1", n_cmd - base);
        end
    endtask

    task automatic test_simultaneous();
        int base, obase;
        base  = n_cmd;
        obase = n_ovr;
        pulse(6'b100001);
        sb.push_back(3'd6);
        tick(15);
        checks++;
        if (n_cmd - base !== 1) begin
            failures++; $display("FAIL simul_count: got %0d cmds, expected 1", n_cmd - base);
        end
        checks++;
        if (n_ovr - obase !== 0) begin
            failures++; $display("FAIL simul_overrun: got %0d, expected 0", n_ovr - obase);
        end
    endtask

    task automatic test_stall_coalesce();
        int base, obase, n;
        base      = n_cmd;
        obase     = n_ovr;
        cmd_ready = 1'b0;
        pulse(6'b000100);
        sb.push_back(3'd3);
        wait_valid(n);
        checks++;
        if (n >= 20 || cmd_op !== 3'd3) begin
            failures++; $display("FAIL stall_first: got valid=%b op=%0d, expected 1/3", cmd_valid, cmd_op);
        end
        tick(3);
        pulse(6'b000100);
        tick(6);
        checks++;
        if (n_ovr - obase !== 1) begin
            failures++; $display("FAIL stall_overrun: got %0d pulses, expected 1", n_ovr - obase);
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd3) begin
            failures++; $display("FAIL stall_hold: got valid=%b op=%0d, expected 1/3", cmd_valid, cmd_op);
        end
        cmd_ready = 1'b1;
        tick(10);
        checks++;
        if (n_cmd - base !== 1) begin
            failures++; $display("FAIL stall_count: got %0d cmds, expected 1", n_cmd - base);
        end
    endtask

    task automatic test_auto_repeat();
        int base, obase;
        base  = n_cmd;
        obase = n_ovr;
        for (int i = 0; i < 26; i++) sb.push_back(3'd4);
        btn[3] = 1'b1;
        tick(300);
        btn[3] = 1'b0;
        tick(20);
        checks++;
        if (n_cmd - base !== 26) begin
            failures++; $display("FAIL repeat_count: got %0d cmds, expected 26", n_cmd - base);
        end
        checks++;
        if (n_ovr - obase !== 0) begin
            failures++; $display("FAIL repeat_overrun: got %0d, expected 0", n_ovr - obase);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++; $display("FAIL repeat_left: got %0d queued, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base      = n_cmd;
        cmd_ready = 1'b0;
        pulse(6'b000010);
        pulse(6'b000100);
        sb.push_back(3'd2);
        sb.push_back(3'd3);
        tick(3);
        cmd_ready = 1'b1;
        tick(15);
        checks++;
        if (n_cmd - base !== 2) begin
            failures++; $display("FAIL b2b_count: got %0d cmds, expected 2", n_cmd - base);
        end
    endtask

    task automatic test_preset();
        int base, obase, n;
        base      = n_cmd;
        obase     = n_ovr;
        cmd_ready = 1'b0;
        pulse(6'b000001);
        sb.push_back(3'd1);
        wait_valid(n);
        pulse(6'b000010);       // queued add2, later discarded by the preset
        tick(5);
        pulse(6'b110000);       // rst1 + rst2 together
        sb.push_back(3'd6);
        tick(5);
        cmd_ready = 1'b1;
        tick(10);
        checks++;
        if (n_cmd - base !== 2) begin
            failures++; $display("FAIL preset_count: got %0d cmds, expected 2", n_cmd - base);
        end
        pulse(6'b000001);
        sb.push_back(3'd1);
        tick(10);
        checks++;
        if (n_cmd - base !== 3) begin
            failures++; $display("FAIL preset_after: got %0d cmds, expected 3", n_cmd - base);
        end
        checks++;
        if (n_ovr - obase !== 0 || sb.size() !== 0) begin
            failures++; $display("FAIL preset_clean: got ovr=%0d queued=%0d, expected 0/0", n_ovr - obase, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_issue();
        test_latency();
        test_simultaneous();
        test_stall_coalesce();
        test_auto_repeat();
        test_back_to_back();
        test_preset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
